// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU operand/opcode decode with a one-cycle valid/ready issue register.
//   clk_w_i, rst_w_i_l (async, active-low)
//   in_valid_w_i_h/in_ready_w_o_h with instr_w_i, pc_w_i, rs1_data_w_i, rs2_data_w_i
//   out_valid_w_o_h/out_ready_w_i_h with a_data_w_o, b_data_w_o, alu_control_w_o,
//   funct3_w_o, rd_w_o, illegal_w_o_h
//   Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with a fully registered in_ready.
module alu_issue (
  input  logic        clk_w_i,
  input  logic        rst_w_i_l,
  input  logic        in_valid_w_i_h,
  output logic        in_ready_w_o_h,
  input  logic [31:0] instr_w_i,
  input  logic [31:0] pc_w_i,
  input  logic [31:0] rs1_data_w_i,
  input  logic [31:0] rs2_data_w_i,
  output logic        out_valid_w_o_h,
  input  logic        out_ready_w_i_h,
  output logic [31:0] a_data_w_o,
  output logic [31:0] b_data_w_o,
  output logic [3:0]  alu_control_w_o,
  output logic [2:0]  funct3_w_o,
  output logic [4:0]  rd_w_o,
  output logic        illegal_w_o_h
);
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        ill;
  } bundle_t;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_u;
  logic        alt_ok, shift;
  bundle_t     dec, out_q;
  logic        out_v, rdy_q, accept;
  assign opc    = instr_w_i[6:0];
  assign f3     = instr_w_i[14:12];
  assign f7     = instr_w_i[31:25];
  assign imm_i  = {{20{instr_w_i[31]}}, instr_w_i[31:20]};
  assign imm_s  = {{20{instr_w_i[31]}}, instr_w_i[31:25], instr_w_i[11:7]};
  assign imm_u  = {instr_w_i[31:12], 12'h000};
  assign alt_ok = (f3 == 3'b000) || (f3 == 3'b101);
  assign shift  = (f3[1:0] == 2'b01);
  always_comb begin
    dec    = '0;
    dec.f3 = f3;
    dec.rd = instr_w_i[11:7];
    case (opc)
      7'b0110011: begin
        dec.a    = rs1_data_w_i;
        dec.b    = rs2_data_w_i;
        dec.ctrl = {f7[5] & alt_ok, f3};
        dec.ill  = !((f7 == 7'h00) || (f7 == 7'h20 && alt_ok));
      end
      7'b0010011: begin
        dec.a    = rs1_data_w_i;
        dec.b    = shift ? {27'b0, instr_w_i[24:20]} : imm_i;
        dec.ctrl = {f3 == 3'b101 && f7 == 7'h20, f3};
        dec.ill  = shift && !((f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20));
      end
      7'b0110111: dec.b = imm_u;
      7'b0010111: begin
        dec.a = pc_w_i;
        dec.b = imm_u;
      end
      7'b0000011: begin
        dec.a = rs1_data_w_i;
        dec.b = imm_i;
      end
      7'b0100011: begin
        dec.a = rs1_data_w_i;
        dec.b = imm_s;
      end
      7'b1100011: begin
        dec.a    = rs1_data_w_i;
        dec.b    = rs2_data_w_i;
        dec.ctrl = 4'b1000;
      end
      7'b1101111, 7'b1100111: begin
        dec.a = pc_w_i;
        dec.b = 32'd4;
      end
      default: dec.ill = 1'b1;
    endcase
  end
`ifdef ALU_ISSUE_SKID_EN
  bundle_t skid_q;
  logic    skid_v, free, skid_nxt;
  assign in_ready_w_o_h = rdy_q;
  assign accept   = in_valid_w_i_h && rdy_q;
  assign free     = !out_v || out_ready_w_i_h;
  // A held skid entry blocks accept (rdy_q is low), so it drains first and order is kept.
  assign skid_nxt = !free && (skid_v || accept);
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      if (free) out_v <= skid_v || accept;
      if (free && (skid_v || accept)) out_q <= skid_v ? skid_q : dec;
      if (!free && accept) skid_q <= dec;
      skid_v <= skid_nxt;
      rdy_q  <= !skid_nxt;
    end
  end
`else
  assign in_ready_w_o_h = rdy_q && (!out_v || out_ready_w_i_h);
  assign accept = in_valid_w_i_h && in_ready_w_o_h;
  // rdy_q holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      out_q <= '0;
      out_v <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      out_v <= accept || (out_v && !out_ready_w_i_h);
      if (accept) out_q <= dec;
    end
  end
`endif
  assign out_valid_w_o_h = out_v;
  assign a_data_w_o      = out_q.a;
  assign b_data_w_o      = out_q.b;
  assign alu_control_w_o = out_q.ctrl;
  assign funct3_w_o      = out_q.f3;
  assign rd_w_o          = out_q.rd;
  assign illegal_w_o_h   = out_q.ill;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with random bundles and a reference decoder.
module tb_alu_issue;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SRA = 4'b1101;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, illegal;
  logic [31:0] instr = 0, pc = 0, rs1 = 0, rs2 = 0, a_data, b_data;
  logic [3:0]  ctrl;
  logic [2:0]  f3;
  logic [4:0]  rd;
  exp_t        q[$];
  exp_t        cur;
  int          checks = 0, failures = 0, acc_cnt = 0, base;
  bit          bp_force = 1, bp_val = 0, done3 = 0;
  logic [6:0]  opcs [0:8] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
  alu_issue dut (
    .clk_w_i(clk), .rst_w_i_l(rst_n),
    .in_valid_w_i_h(in_valid), .in_ready_w_o_h(in_ready),
    .instr_w_i(instr), .pc_w_i(pc), .rs1_data_w_i(rs1), .rs2_data_w_i(rs2),
    .out_valid_w_o_h(out_valid), .out_ready_w_i_h(out_ready),
    .a_data_w_o(a_data), .b_data_w_o(b_data), .alu_control_w_o(ctrl),
    .funct3_w_o(f3), .rd_w_o(rd), .illegal_w_o_h(illegal)
  );
  always #5 clk = ~clk;
  always @(negedge clk) out_ready = bp_force ? bp_val : ($urandom_range(0, 3) != 0);
  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pcv, r1, r2);
    exp_t e;
    logic [2:0]  fn3 = i[14:12];
    logic [6:0]  fn7 = i[31:25];
    logic [31:0] imm_i = {{20{i[31]}}, i[31:20]};
    logic [31:0] imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    logic [31:0] imm_u = {i[31:12], 12'h000};
    logic        alt = (fn3 == 0) || (fn3 == 5);
    e = '0;
    e.f3 = fn3;
    e.rd = i[11:7];
    case (i[6:0])
      7'h33: begin
        e.a = r1; e.b = r2;
        e.ctrl = {fn7[5] && alt, fn3};
        e.ill = !(fn7 == 0 || (fn7 == 7'h20 && alt));
      end
      7'h13: begin
        e.a = r1;
        if (fn3 == 1 || fn3 == 5) begin
          e.b = 32'(i[24:20]);
          e.ctrl = (fn3 == 5 && fn7 == 7'h20) ? OP_SRA : {1'b0, fn3};
          e.ill = !(fn7 == 0 || (fn3 == 5 && fn7 == 7'h20));
        end else begin
          e.b = imm_i;
          e.ctrl = {1'b0, fn3};
        end
      end
      7'h37: e.b = imm_u;
      7'h17: begin e.a = pcv; e.b = imm_u; end
      7'h03: begin e.a = r1; e.b = imm_i; end
      7'h23: begin e.a = r1; e.b = imm_s; end
      7'h63: begin e.a = r1; e.b = r2; e.ctrl = OP_SUB; end
      7'h6F, 7'h67: begin e.a = pcv; e.b = 32'd4; e.ctrl = OP_ADD; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [31:0] i = $urandom;
    int          s = $urandom_range(0, 3);
    int          k = $urandom_range(0, 9);
    i[31:25] = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : i[31:25];
    if (k < 9) i[6:0] = opcs[k];
    return i;
  endfunction
  task automatic send(input logic [31:0] ins, pcv, r1, r2, input exp_t e);
    int n = 0;
    @(negedge clk);
    in_valid = 1; instr = ins; pc = pcv; rs1 = r1; rs2 = r2;
    forever begin
      #2;
      if (in_ready) begin
        q.push_back(e);
        acc_cnt++;
        break;
      end
      if (++n > 100) begin
        checks++; failures++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic send_m(input logic [31:0] ins, pcv, r1, r2);
    send(ins, pcv, r1, r2, model(ins, pcv, r1, r2));
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 300 && (q.size() != 0 || out_valid); i++) @(posedge clk);
    chk(nm, 80'(q.size()), 80'd0);
  endtask
  always @(negedge clk) begin
    #3;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_issue actual=%h required=none", {a_data, b_data, ctrl, f3, rd, illegal});
      end else begin
        cur = q.pop_front();
        chk("issue", 80'({a_data, b_data, ctrl, f3, rd, illegal}), 80'(cur));
      end
    end
  end
  initial begin
    #3;
    chk("reset_out_valid", 80'(out_valid), 80'd0);
    chk("reset_in_ready", 80'(in_ready), 80'd0);
    chk("reset_data", 80'({a_data, b_data, ctrl, f3, rd, illegal}), 80'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("ready_before_edge", 80'(in_ready), 80'd0);
    @(posedge clk);
    #1 chk("ready_after_edge", 80'(in_ready), 80'd1);
    bp_val = 1;
    @(negedge clk);
    send(32'h002081B3, 32'h100, 32'd5, 32'd7, exp_t'{32'd5, 32'd7, 4'b0000, 3'd0, 5'd3, 1'b0});
    chk("latency", 80'(out_valid), 80'd1);
    send(32'h4030D093, 32'h104, 32'h80000000, 32'd9, exp_t'{32'h80000000, 32'd3, 4'b1101, 3'd5, 5'd1, 1'b0});
    send(32'h123452B7, 32'h108, 32'd11, 32'd12, exp_t'{32'd0, 32'h12345000, 4'b0000, 3'd5, 5'd5, 1'b0});
    send(32'h0000007F, 32'h10C, 32'd13, 32'd14, exp_t'{32'd0, 32'd0, 4'b0000, 3'd0, 5'd0, 1'b1});
    drain("drain_directed");
    @(posedge clk);
    #1 bp_val = 0;
    base = acc_cnt;
    fork
      begin
        send_m(32'h00310233, 32'h200, 32'd1, 32'd2);
        send_m(32'h40418333, 32'h204, 32'd10, 32'd3);
        send_m(32'hFFF28393, 32'h208, 32'd20, 32'd0);
        done3 = 1;
      end
    join_none
    repeat (5) @(negedge clk);
    #4;
`ifdef ALU_ISSUE_SKID_EN
    chk("held_count", 80'(acc_cnt - base), 80'd2);
`else
    chk("held_count", 80'(acc_cnt - base), 80'd1);
`endif
    chk("held_in_ready", 80'(in_ready), 80'd0);
    bp_val = 1;
    for (int i = 0; i < 50 && !done3; i++) @(posedge clk);
    chk("bp_done", 80'(done3), 80'd1);
    drain("drain_bp");
    bp_force = 0;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      send_m(rand_instr(), $urandom, $urandom, $urandom);
    end
    drain("drain_random");
    @(posedge clk);
    #1 bp_force = 1; bp_val = 0;
    send_m(32'h00A00513, 32'h300, 32'd0, 32'd0);
    @(negedge clk);
    #1 chk("pre_reset_valid", 80'(out_valid), 80'd1);
    rst_n = 0;
    #1;
    chk("async_out_valid", 80'(out_valid), 80'd0);
    chk("async_in_ready", 80'(in_ready), 80'd0);
    chk("async_data", 80'({a_data, b_data, ctrl, f3, rd, illegal}), 80'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    bp_val = 1;
    @(posedge clk);
    send(32'h002081B3, 32'h400, 32'd5, 32'd7, exp_t'{32'd5, 32'd7, 4'b0000, 3'd0, 5'd3, 1'b0});
    chk("post_reset_latency", 80'(out_valid), 80'd1);
    drain("drain_post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits to match the RV32 ALU.
REQ-002 clk_w_i  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_w_i_l  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid_w_i_h  input  1  upstream instruction/operand bundle valid.
REQ-005 in_ready_w_o_h  output  1  block accepts a bundle this cycle.
REQ-006 instr_w_i  input  32  RV32I instruction word.
REQ-007 pc_w_i  input  32  instruction PC.
REQ-008 rs1_data_w_i, rs2_data_w_i  input  32 each  register-file read data.
REQ-009 out_valid_w_o_h  output  1  issued ALU bundle valid.
REQ-010 out_ready_w_i_h  input  1  ALU stage consumes the bundle.
REQ-011 a_data_w_o, b_data_w_o  output  32 each  ALU operands.
REQ-012 alu_control_w_o  output  4  ALU op code.
REQ-013 funct3_w_o  output  3  instr[14:12] pass-through, used for branch/load sizing.
REQ-014 rd_w_o  output  5  destination register, instr[11:7].
REQ-015 illegal_w_o_h  output  1  bundle carries an unsupported encoding.

Function
REQ-016 ALU op encoding SHALL be: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
REQ-017 The bundle transfers in on in_valid&&in_ready and out on out_valid&&out_ready; no bundle SHALL be dropped or duplicated, and issue order SHALL equal accept order.
REQ-018 Latency SHALL be one cycle: a bundle accepted at edge N is presented with out_valid=1 after edge N when the output is free.
REQ-019 Outputs SHALL be driven from registers only, and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 The OP opcode (0110011) SHALL decode as: a=rs1, b=rs2, ctrl={f7[5]&(f3==000||f3==101), f3}; funct7 other than 0000000, or 0100000 with f3 of 000 or 101, SHALL flag illegal.
REQ-021 The OP-IMM opcode (0010011) SHALL decode as: a=rs1, b=sign-extended I-imm, ctrl={0,f3}.
REQ-022 OP-IMM exception: f3=001/101 SHALL use b=zero-extended shamt instr[24:20], and SRAI (f7=0100000, f3=101) SHALL give ctrl 1101.
REQ-023 OP-IMM illegal cases: any other f7 on a shift SHALL flag illegal.
REQ-024 LUI SHALL decode as: a=0, b={instr[31:12],12'b0}, ADD.
REQ-025 AUIPC SHALL decode as: a=pc, b=U-imm, ADD.
REQ-026 LOAD SHALL decode as: a=rs1, b=I-imm, ADD.
REQ-027 STORE SHALL decode as: a=rs1, b=S-imm, ADD.
REQ-028 BRANCH SHALL decode as: a=rs1, b=rs2, SUB.
REQ-029 JAL and JALR SHALL decode as: a=pc, b=32'd4, ADD.
REQ-030 Any other opcode SHALL set illegal=1 with ctrl 0000 and a=b=0; rd and funct3 SHALL still pass through.
REQ-031 Simultaneous accept and issue in the same cycle SHALL sustain one bundle per cycle with no bubble.

Reset
REQ-032 While rst_w_i_l=0: out_valid=0, in_ready=0, and all data outputs, illegal and internal occupancy state SHALL be 0, effective immediately without a clock edge.
REQ-033 Reset mid-operation SHALL discard all held bundles.
REQ-034 in_ready SHALL rise no earlier than the first rising edge after deassertion.

Configuration
REQ-035 With ALU_ISSUE_SKID_EN defined, a 2-entry skid buffer SHALL be used: in_ready=registered "skid entry empty", independent of out_ready in the same cycle; one extra bundle is absorbed when out_ready drops.
REQ-036 Without ALU_ISSUE_SKID_EN, a single output register SHALL be used with in_ready = !out_valid || out_ready (combinational path from out_ready).
REQ-037 Decoding, latency (REQ-018) and ordering SHALL be identical in both builds.

Verification
REQ-038 instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> next cycle out_valid=1, a=5, b=7, ctrl=0000, rd=3, illegal=0.
REQ-039 instr 0x4030D093 (srai x1,x1,3), rs1=0x80000000 -> a=0x80000000, b=3, ctrl=1101.
REQ-040 instr 0x123452B7 (lui x5,0x12345) -> a=0, b=0x12345000, ctrl=0000, rd=5.
REQ-041 instr 0x0000007F -> illegal=1, ctrl=0000, a=b=0.
REQ-042 Backpressure: three back-to-back bundles with out_ready=0 for 3 cycles, then 1 -> all three issued in order, none lost.
REQ-043 Backpressure, per build: with ALU_ISSUE_SKID_EN, exactly two are held before in_ready=0; without it, one.
REQ-044 Assert rst_w_i_l=0 while out_valid=1 and out_ready=0 -> out_valid=0 immediately; after release, the first accepted bundle issues normally.
